mem_port_arbiter: RTL and testbench

Single-port arbiter sharing the 1024-word unified instruction/data memory of the 32-bit pipelined core between three requesters: the program loader, the MEM-stage load/store port and the IF-stage fetch port. It grants at most one access per cycle, tracks the owner of each outstanding read and prevents fetch starvation. It replaces direct `Mem[...]` indexing in the pipeline stages with a registered-read SRAM behind one arbitrated port.

---
 rtl/mem_port_arbiter.sv | 77 +++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered-read SRAM port between loader, data and fetch
// requesters, with loader locking, fetch starvation promotion and read-owner tracking.
module mem_port_arbiter #(
   parameter int AW = 10,
   parameter int DW = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic          ld_lock,
   input  logic [31:0]   ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [31:0]   d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          i_req,
   input  logic [31:0]   i_addr,
   output logic          ld_gnt,
   output logic          d_gnt,
   output logic          i_gnt,
   output logic          ld_rvalid,
   output logic          d_rvalid,
   output logic          i_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          locked
);
   typedef enum logic {RUN, LOCK} state_t;
   state_t state, state_nxt;
   logic [1:0] rst_sync;
   logic [3:0] starve_cnt, cnt_nxt;
   logic [2:0] rv;
   logic ready, run_rules, promo;
   logic unused_addr;
   assign unused_addr = ^{ld_addr[31:AW], d_addr[31:AW], i_addr[31:AW]};
   // grants stay off until reset release has passed through two flops
   assign ready = rst_sync[1];
   always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) begin
         rst_sync   <= '0;
         state      <= RUN;
         starve_cnt <= '0;
         rv         <= '0;
      end else begin
         rst_sync   <= {rst_sync[0], 1'b1};
         state      <= state_nxt;
         starve_cnt <= cnt_nxt;
         rv         <= {ld_gnt & ~ld_we, d_gnt & ~d_we, i_gnt};
      end
   always_comb begin
      run_rules = ready && (state == RUN || !ld_lock);
      promo     = starve_cnt == MAX_WAIT[3:0];
      ld_gnt    = ready && ld_req;
      d_gnt     = run_rules && !ld_req && d_req && !(promo && i_req);
      i_gnt     = run_rules && !ld_req && i_req && (promo || !d_req);
      state_nxt = (ld_lock && (ld_gnt || state == LOCK)) ? LOCK : RUN;
      cnt_nxt   = !run_rules ? starve_cnt :
                  (i_req && !i_gnt) ? (promo ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
   end
   always_comb begin
      mem_en    = ld_gnt | d_gnt | i_gnt;
      mem_we    = ld_gnt ? ld_we : d_gnt & d_we;
      mem_addr  = ld_gnt ? ld_addr[AW-1:0] : d_gnt ? d_addr[AW-1:0] :
                  i_gnt ? i_addr[AW-1:0] : '0;
      mem_wdata = ld_gnt ? ld_wdata : d_gnt ? d_wdata : '0;
      rdata     = |rv ? mem_rdata : '0;
      {ld_rvalid, d_rvalid, i_rvalid} = rv;
      locked    = state == LOCK;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against
// a priority-list reference model with its own copy of memory.
module tb_mem_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int MW = 4;
   logic clk1 = 0;
   logic rst_n = 0;
   logic ld_req, ld_we, ld_lock, d_req, d_we, i_req;
   logic [31:0] ld_addr, d_addr, i_addr;
   logic [DW-1:0] ld_wdata, d_wdata, rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic ld_gnt, d_gnt, i_gnt, ld_rvalid, d_rvalid, i_rvalid, mem_en, mem_we, locked;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] sram [1024];
   int tests = 0;
   int fails = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .i_req(i_req), .i_addr(i_addr),
      .ld_gnt(ld_gnt), .d_gnt(d_gnt), .i_gnt(i_gnt),
      .ld_rvalid(ld_rvalid), .d_rvalid(d_rvalid), .i_rvalid(i_rvalid), .rdata(rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .locked(locked)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1)
      if (mem_en) begin
         if (mem_we) sram[mem_addr] <= mem_wdata;
         else mem_rdata <= sram[mem_addr];
      end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic clr();
      {ld_req, ld_we, ld_lock, d_req, d_we, i_req} = '0;
      {ld_addr, d_addr, i_addr, ld_wdata, d_wdata} = '0;
   endtask

   task automatic idle2();
      @(negedge clk1); clr();
      @(negedge clk1);
   endtask

   task automatic test_reset();
      rst_n = 0;
      {ld_req, d_req, i_req} = 3'b111;
      {ld_we, d_we, ld_lock} = 3'b000;
      ld_addr = 3; d_addr = 4; i_addr = 5;
      ld_wdata = 0; d_wdata = 0;
      repeat (2) @(negedge clk1);
      #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt, ld_rvalid, d_rvalid, i_rvalid, mem_en, mem_we, locked} !== 9'b0
          || mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
         fails++;
         $display("FAIL reset_outputs got gnt=%b rv=%b en=%b we=%b lk=%b addr=%h rdata=%h exp all 0",
                  {ld_gnt, d_gnt, i_gnt}, {ld_rvalid, d_rvalid, i_rvalid}, mem_en, mem_we, locked, mem_addr, rdata);
      end
      @(negedge clk1); rst_n = 1;
      @(negedge clk1); #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b000) begin
         fails++; $display("FAIL reset_sync_gnt got %b exp 000", {ld_gnt, d_gnt, i_gnt});
      end
      @(negedge clk1); #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b100 || mem_addr !== 10'd3) begin
         fails++; $display("FAIL reset_first_gnt got %b addr %h exp 100 addr 003", {ld_gnt, d_gnt, i_gnt}, mem_addr);
      end
   endtask

   task automatic test_loader_burst();
      idle2();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk1);
         ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 32'(k); ld_wdata = 32'h11 + 32'(k);
         d_req = 1; d_we = 0; d_addr = 0; i_req = 1; i_addr = 0;
         #1;
         tests++;
         if ({ld_gnt, d_gnt, i_gnt} !== 3'b100 || locked !== (k > 0) || mem_we !== 1'b1
             || mem_addr !== 10'(k) || mem_wdata !== 32'h11 + 32'(k)) begin
            fails++;
            $display("FAIL burst_beat%0d got gnt=%b lk=%b we=%b addr=%h wd=%h exp 100 lk=%0d we=1 addr=%0d wd=%h",
                     k, {ld_gnt, d_gnt, i_gnt}, locked, mem_we, mem_addr, mem_wdata, k > 0, k, 32'h11 + 32'(k));
         end
      end
      @(negedge clk1); ld_req = 0; ld_lock = 0; ld_we = 0; #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b010 || locked !== 1'b1) begin
         fails++; $display("FAIL burst_drop got gnt=%b lk=%b exp 010 lk=1", {ld_gnt, d_gnt, i_gnt}, locked);
      end
      @(negedge clk1); d_req = 0; #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b001 || locked !== 1'b0 || d_rvalid !== 1'b1 || rdata !== 32'h11) begin
         fails++; $display("FAIL burst_fetch got gnt=%b lk=%b drv=%b rdata=%h exp 001 lk=0 drv=1 rdata=11",
                           {ld_gnt, d_gnt, i_gnt}, locked, d_rvalid, rdata);
      end
      @(negedge clk1); i_req = 0; #1;
      tests++;
      if ({ld_rvalid, d_rvalid, i_rvalid} !== 3'b001 || rdata !== 32'h11) begin
         fails++; $display("FAIL burst_irv got rv=%b rdata=%h exp 001 rdata=11", {ld_rvalid, d_rvalid, i_rvalid}, rdata);
      end
   endtask

   task automatic test_starvation();
      idle2();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk1);
         d_req = 1; d_we = 0; d_addr = 32'(k); i_req = 1; i_addr = 0;
         #1;
         tests++;
         if ({ld_gnt, d_gnt, i_gnt} !== ((k == MW) ? 3'b001 : 3'b010)) begin
            fails++; $display("FAIL starve_cyc%0d got %b exp %b", k, {ld_gnt, d_gnt, i_gnt}, (k == MW) ? 3'b001 : 3'b010);
         end
      end
   endtask

   task automatic test_read_return();
      idle2();
      @(negedge clk1); d_req = 1; d_we = 1; d_addr = 7; d_wdata = 32'hDEADBEEF;
      @(negedge clk1); d_addr = 8; d_wdata = 32'h1;
      @(negedge clk1); d_we = 0; d_addr = 7; #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b010 || mem_we !== 1'b0) begin
         fails++; $display("FAIL rr_dgnt got %b we=%b exp 010 we=0", {ld_gnt, d_gnt, i_gnt}, mem_we);
      end
      @(negedge clk1); d_req = 0; i_req = 1; i_addr = 8; #1;
      tests++;
      if ({ld_gnt, d_gnt, i_gnt} !== 3'b001 || {ld_rvalid, d_rvalid, i_rvalid} !== 3'b010 || rdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL rr_dret got gnt=%b rv=%b rdata=%h exp 001 010 deadbeef",
                           {ld_gnt, d_gnt, i_gnt}, {ld_rvalid, d_rvalid, i_rvalid}, rdata);
      end
      @(negedge clk1); i_req = 0; #1;
      tests++;
      if ({ld_rvalid, d_rvalid, i_rvalid} !== 3'b001 || rdata !== 32'h1) begin
         fails++; $display("FAIL rr_iret got rv=%b rdata=%h exp 001 00000001", {ld_rvalid, d_rvalid, i_rvalid}, rdata);
      end
   endtask

   task automatic test_wrap();
      idle2();
      @(negedge clk1); d_req = 1; d_we = 1; d_addr = 32'h0000_0405; d_wdata = 32'hA5; #1;
      tests++;
      if (mem_addr !== 10'd5 || mem_we !== 1'b1 || mem_en !== 1'b1 || mem_wdata !== 32'hA5) begin
         fails++; $display("FAIL wrap_write got addr=%h we=%b en=%b wd=%h exp 005 1 1 a5", mem_addr, mem_we, mem_en, mem_wdata);
      end
      @(negedge clk1); d_req = 0; d_we = 0; i_req = 1; i_addr = 32'hFFFF_FC05; #1;
      tests++;
      if (i_gnt !== 1'b1 || mem_addr !== 10'd5) begin
         fails++; $display("FAIL wrap_fetch got ig=%b addr=%h exp 1 005", i_gnt, mem_addr);
      end
      @(negedge clk1); i_req = 0; #1;
      tests++;
      if (i_rvalid !== 1'b1 || rdata !== 32'hA5) begin
         fails++; $display("FAIL wrap_read got irv=%b rdata=%h exp 1 a5", i_rvalid, rdata);
      end
   endtask

   task automatic test_async_reset();
      idle2();
      @(negedge clk1); ld_req = 1; ld_lock = 1; ld_we = 0; ld_addr = 5; #1;
      tests++;
      if (ld_gnt !== 1'b1) begin
         fails++; $display("FAIL ar_gnt got %b exp 1", ld_gnt);
      end
      @(posedge clk1); #2;
      rst_n = 0; clr(); #1;
      tests++;
      if ({ld_rvalid, d_rvalid, i_rvalid} !== 3'b000 || locked !== 1'b0) begin
         fails++; $display("FAIL ar_suppress got rv=%b lk=%b exp 000 0", {ld_rvalid, d_rvalid, i_rvalid}, locked);
      end
      @(negedge clk1); rst_n = 1;
      @(negedge clk1);
      @(negedge clk1); #1;
      tests++;
      if ({ld_rvalid, d_rvalid, i_rvalid} !== 3'b000) begin
         fails++; $display("FAIL ar_after got rv=%b exp 000", {ld_rvalid, d_rvalid, i_rvalid});
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] ref_mem [1024];
      bit m_lock = 0;
      int m_cnt = 0;
      logic [2:0] m_rv = '0;
      logic [DW-1:0] m_rd = '0;
      for (int j = 0; j < 1024; j++) ref_mem[j] = sram[j];
      for (int n = 0; n < 600; n++) begin
         logic [2:0] eg;
         logic [AW-1:0] ea;
         logic ew;
         logic [DW-1:0] ewd;
         bit arb_free;
         @(negedge clk1);
         ld_req = $urandom_range(0, 4) == 0; ld_lock = $urandom_range(0, 2) == 0;
         ld_we = 1'($urandom); ld_addr = $urandom; ld_wdata = $urandom;
         d_req = $urandom_range(0, 3) != 0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
         i_req = $urandom_range(0, 3) != 0; i_addr = $urandom;
         // priority list: loader, starving fetch, data, fetch; a held lock admits only the loader
         arb_free = !m_lock || !ld_lock;
         if (ld_req) eg = 3'b100;
         else if (!arb_free) eg = 3'b000;
         else if (m_cnt == MW && i_req) eg = 3'b001;
         else if (d_req) eg = 3'b010;
         else if (i_req) eg = 3'b001;
         else eg = 3'b000;
         ea = eg[2] ? ld_addr[AW-1:0] : eg[1] ? d_addr[AW-1:0] : eg[0] ? i_addr[AW-1:0] : '0;
         ew = eg[2] ? ld_we : eg[1] ? d_we : 1'b0;
         ewd = eg[2] ? ld_wdata : eg[1] ? d_wdata : '0;
         #1;
         tests++;
         if ({ld_gnt, d_gnt, i_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {eg, |eg, ew, ea, ewd}) begin
            fails++; $display("FAIL rnd_port n=%0d got gnt=%b en=%b we=%b addr=%h wd=%h exp %b %b %b %h %h",
                              n, {ld_gnt, d_gnt, i_gnt}, mem_en, mem_we, mem_addr, mem_wdata, eg, |eg, ew, ea, ewd);
         end
         tests++;
         if ({ld_rvalid, d_rvalid, i_rvalid} !== m_rv || locked !== m_lock || (m_rv != 0 && rdata !== m_rd)) begin
            fails++; $display("FAIL rnd_ret n=%0d got rv=%b lk=%b rdata=%h exp %b %b %h",
                              n, {ld_rvalid, d_rvalid, i_rvalid}, locked, rdata, m_rv, m_lock, m_rd);
         end
         m_rv = ew ? 3'b000 : eg;
         if (|eg && !ew) m_rd = ref_mem[ea];
         if (ew) ref_mem[ea] = ewd;
         if (arb_free) m_cnt = (i_req && !eg[0]) ? ((m_cnt < MW) ? m_cnt + 1 : MW) : 0;
         m_lock = ld_lock && (m_lock || eg[2]);
      end
      @(negedge clk1); clr();
   endtask

   initial begin
      for (int j = 0; j < 1024; j++) sram[j] = '0;
      clr();
      test_reset();
      test_loader_burst();
      test_starvation();
      test_read_return();
      test_wrap();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
